// File: rtl/ad_pkg.sv
// Shared constants and state encoding for the serial ADC responder emulation.
package ad_pkg;

    localparam int DATA_W_DEF     = 16;
    localparam int LEAD_ZEROS_DEF = 2;
    localparam int FRAME_LEN_DEF  = DATA_W_DEF + LEAD_ZEROS_DEF;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ad_state_e;

endpackage

// File: rtl/ad_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin, followed by a history flop
// and registered edge pulses (valid three clk_sys cycles after the pin edge).
module ad_sync_edge (
    input  logic clk_sys,
    input  logic rst_n,
    input  logic pin_i,
    output logic lvl_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q, sync_q, hist_q, rise_q, fall_q;

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            hist_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            meta_q <= pin_i;
            sync_q <= meta_q;
            hist_q <= sync_q;
            rise_q <= sync_q & ~hist_q;
            fall_q <= ~sync_q & hist_q;
        end
    end

    assign lvl_o  = sync_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/ad_slave_emu.sv
// Serial ADC channel emulator: answers cs_n/sclk from the initiator by shifting
// a buffered word out on sdata, MSB first, after LEAD_ZEROS zero bits.
module ad_slave_emu
    import ad_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int LEAD_ZEROS = LEAD_ZEROS_DEF,
    parameter int CNT_W      = 5
) (
    input  logic              clk_sys,
    input  logic              rst_n,
    input  logic              cs_n,
    input  logic              sclk,
    output logic              sdata,
    input  logic [DATA_W-1:0] din,
    input  logic              din_vld,
    output logic              din_rdy,
    output logic              frame_done,
    output logic              frame_abort,
    output logic              underrun
);

    localparam int               FRAME_LEN = DATA_W + LEAD_ZEROS;
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(FRAME_LEN - 1);

    logic cs_lvl, cs_rise, cs_fall;
    logic sclk_lvl, sclk_rise, sclk_fall;
    logic unused_sclk;

    ad_sync_edge u_cs_sync (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .pin_i   (cs_n),
        .lvl_o   (cs_lvl),
        .rise_o  (cs_rise),
        .fall_o  (cs_fall)
    );

    ad_sync_edge u_sclk_sync (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .pin_i   (sclk),
        .lvl_o   (sclk_lvl),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall)
    );

    assign unused_sclk = sclk_lvl ^ sclk_rise;

    ad_state_e            state_q;
    logic [FRAME_LEN-1:0] shift_q;
    logic [CNT_W-1:0]     bit_cnt_q;
    logic [DATA_W-1:0]    buf_q, last_word_q;
    logic                 buf_full_q, buf_full_d;
    logic                 din_rdy_q;
    logic                 frame_done_q, frame_abort_q, underrun_q;
    logic                 accept, load_from_buf;

    assign accept        = din_vld && din_rdy_q;
    assign load_from_buf = (state_q == IDLE) && cs_fall && buf_full_q;

    // Accept only happens while empty, so it never collides with a load.
    always_comb begin
        buf_full_d = buf_full_q;
        if (load_from_buf) buf_full_d = 1'b0;
        if (accept)        buf_full_d = 1'b1;
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            buf_q         <= '0;
            last_word_q   <= '0;
            buf_full_q    <= 1'b0;
            din_rdy_q     <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_abort_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            frame_done_q  <= 1'b0;
            frame_abort_q <= 1'b0;
            underrun_q    <= 1'b0;
            buf_full_q    <= buf_full_d;
            din_rdy_q     <= !buf_full_d;
            if (accept) buf_q <= din;

            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_q   <= SHIFT;
                        bit_cnt_q <= '0;
                        if (buf_full_q) begin
                            shift_q     <= FRAME_LEN'(buf_q);
                            last_word_q <= buf_q;
                        end else begin
                            shift_q    <= FRAME_LEN'(last_word_q);
                            underrun_q <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        state_q   <= IDLE;
                        shift_q   <= '0;
                        bit_cnt_q <= '0;
                        if (bit_cnt_q == LAST_BIT) frame_done_q  <= 1'b1;
                        else                       frame_abort_q <= 1'b1;
                    end else if (sclk_fall && !cs_lvl) begin
                        // Past the last bit the register drains to zero while the count holds.
                        shift_q <= {shift_q[FRAME_LEN-2:0], 1'b0};
                        if (bit_cnt_q != LAST_BIT) bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sdata       = shift_q[FRAME_LEN-1];
    assign din_rdy     = din_rdy_q;
    assign frame_done  = frame_done_q;
    assign frame_abort = frame_abort_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_ad_slave_emu.sv
// Bench for ad_slave_emu: drives initiator-style cs_n/sclk frames and checks
// the shifted bits against an expected-word queue plus the status pulses.
module tb_ad_slave_emu;

    localparam int FL = 18;

    logic        clk_sys = 1'b0;
    logic        rst_n   = 1'b0;
    logic        cs_n    = 1'b1;
    logic        sclk    = 1'b1;
    logic        sdata;
    logic [15:0] din     = 16'h0;
    logic        din_vld = 1'b0;
    logic        din_rdy, frame_done, frame_abort, underrun;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0, abort_cnt = 0, under_cnt = 0;
    logic [FL-1:0] exp_q[$];

    ad_slave_emu dut (
        .clk_sys     (clk_sys),
        .rst_n       (rst_n),
        .cs_n        (cs_n),
        .sclk        (sclk),
        .sdata       (sdata),
        .din         (din),
        .din_vld     (din_vld),
        .din_rdy     (din_rdy),
        .frame_done  (frame_done),
        .frame_abort (frame_abort),
        .underrun    (underrun)
    );

    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) begin
        if (frame_done  === 1'b1) done_cnt++;
        if (frame_abort === 1'b1) abort_cnt++;
        if (underrun    === 1'b1) under_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time expired, required completion");
        $fatal(1, "watchdog");
    end

    task automatic load_word(input logic [15:0] w);
        int t = 0;
        while (din_rdy !== 1'b1 && t < 20) begin
            @(negedge clk_sys);
            t++;
        end
        n_cmp++;
        if (din_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL load_rdy: din_rdy=%b required 1", din_rdy);
        end
        din = w;
        din_vld = 1'b1;
        @(negedge clk_sys);
        din_vld = 1'b0;
    endtask

    task automatic run_frame(input int nsclk, input bit inject, input logic [15:0] inj_word,
                             input int rst_at, output logic [31:0] bits,
                             output logic sd_rst, output logic rdy_rst);
        bits = '0;
        sd_rst = 1'b0;
        rdy_rst = 1'b0;
        @(negedge clk_sys);
        cs_n = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_sys);
            if (inject && c == 2) begin
                din = inj_word;
                din_vld = 1'b1;
            end else begin
                din_vld = 1'b0;
            end
        end
        for (int i = 0; i < nsclk; i++) begin
            if (i == rst_at) begin
                rst_n = 1'b0;
                @(negedge clk_sys);
                sd_rst = sdata;
                rdy_rst = din_rdy;
                rst_n = 1'b1;
            end
            bits = {bits[30:0], sdata};
            sclk = 1'b0;
            repeat (4) @(negedge clk_sys);
            sclk = 1'b1;
            repeat (4) @(negedge clk_sys);
        end
        cs_n = 1'b1;
        repeat (8) @(negedge clk_sys);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk_sys);
        n_cmp++;
        if (sdata !== 1'b0) begin n_err++; $display("FAIL rst_sdata: got %b required 0", sdata); end
        n_cmp++;
        if (din_rdy !== 1'b0) begin n_err++; $display("FAIL rst_rdy: got %b required 0", din_rdy); end
        n_cmp++;
        if ({frame_done, frame_abort, underrun} !== 3'b000) begin
            n_err++;
            $display("FAIL rst_pulses: got %b required 000", {frame_done, frame_abort, underrun});
        end
        rst_n = 1'b1;
        @(negedge clk_sys);
        n_cmp++;
        if (din_rdy !== 1'b1) begin n_err++; $display("FAIL rst_rdy_rise: got %b required 1", din_rdy); end
        repeat (4) @(negedge clk_sys);
        n_cmp++;
        if (done_cnt + abort_cnt + under_cnt != 0) begin
            n_err++;
            $display("FAIL rst_idle_pulses: got %0d required 0", done_cnt + abort_cnt + under_cnt);
        end
    endtask

    task automatic test_single_frame();
        logic [31:0] bits;
        logic [FL-1:0] exp;
        logic sd, rdy;
        int d0 = done_cnt, a0 = abort_cnt, u0 = under_cnt;
        load_word(16'hA5C3);
        exp_q.push_back({2'b00, 16'hA5C3});
        run_frame(18, 1'b0, 16'h0, -1, bits, sd, rdy);
        exp = exp_q.pop_front();
        n_cmp++;
        if (bits[FL-1:0] !== exp) begin n_err++; $display("FAIL single_bits: got %h required %h", bits[FL-1:0], exp); end
        n_cmp++;
        if (done_cnt - d0 != 1 || abort_cnt != a0 || under_cnt != u0) begin
            n_err++;
            $display("FAIL single_pulses: done %0d abort %0d under %0d required 1 0 0",
                     done_cnt - d0, abort_cnt - a0, under_cnt - u0);
        end
        n_cmp++;
        if (din_rdy !== 1'b1) begin n_err++; $display("FAIL single_rdy: got %b required 1", din_rdy); end
    endtask

    task automatic test_underrun();
        logic [31:0] bits;
        logic [FL-1:0] exp;
        logic sd, rdy;
        int d0 = done_cnt, u0 = under_cnt;
        exp_q.push_back({2'b00, 16'hA5C3});
        run_frame(18, 1'b0, 16'h0, -1, bits, sd, rdy);
        exp = exp_q.pop_front();
        n_cmp++;
        if (bits[FL-1:0] !== exp) begin n_err++; $display("FAIL underrun_bits: got %h required %h", bits[FL-1:0], exp); end
        n_cmp++;
        if (under_cnt - u0 != 1 || done_cnt - d0 != 1) begin
            n_err++;
            $display("FAIL underrun_pulses: under %0d done %0d required 1 1", under_cnt - u0, done_cnt - d0);
        end
    endtask

    task automatic test_abort();
        logic [31:0] bits;
        logic [FL-1:0] exp;
        logic sd, rdy;
        int d0 = done_cnt, a0 = abort_cnt;
        load_word(16'h5A5A);
        run_frame(9, 1'b0, 16'h0, -1, bits, sd, rdy);
        n_cmp++;
        if (bits[8:0] !== 9'b00_0101101) begin n_err++; $display("FAIL abort_bits: got %b required 000101101", bits[8:0]); end
        n_cmp++;
        if (abort_cnt - a0 != 1 || done_cnt != d0) begin
            n_err++;
            $display("FAIL abort_pulses: abort %0d done %0d required 1 0", abort_cnt - a0, done_cnt - d0);
        end
        n_cmp++;
        if (sdata !== 1'b0) begin n_err++; $display("FAIL abort_sdata: got %b required 0", sdata); end
        load_word(16'h0F0F);
        exp_q.push_back({2'b00, 16'h0F0F});
        run_frame(18, 1'b0, 16'h0, -1, bits, sd, rdy);
        exp = exp_q.pop_front();
        n_cmp++;
        if (bits[FL-1:0] !== exp) begin n_err++; $display("FAIL abort_next_bits: got %h required %h", bits[FL-1:0], exp); end
    endtask

    task automatic test_long_frame();
        logic [31:0] bits;
        logic [FL-1:0] exp;
        logic sd, rdy;
        int d0 = done_cnt, a0 = abort_cnt;
        load_word(16'hFFFF);
        exp_q.push_back({2'b00, 16'hFFFF});
        run_frame(22, 1'b0, 16'h0, -1, bits, sd, rdy);
        exp = exp_q.pop_front();
        n_cmp++;
        if (bits[21:0] !== {exp, 4'b0000}) begin
            n_err++;
            $display("FAIL long_bits: got %h required %h", bits[21:0], {exp, 4'b0000});
        end
        n_cmp++;
        if (done_cnt - d0 != 1 || abort_cnt != a0) begin
            n_err++;
            $display("FAIL long_pulses: done %0d abort %0d required 1 0", done_cnt - d0, abort_cnt - a0);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] bits;
        logic [FL-1:0] exp;
        logic sd, rdy;
        int u0 = under_cnt;
        exp_q.push_back({2'b00, 16'hFFFF});
        run_frame(18, 1'b1, 16'h1234, -1, bits, sd, rdy);
        exp = exp_q.pop_front();
        n_cmp++;
        if (bits[FL-1:0] !== exp) begin n_err++; $display("FAIL simul_bits: got %h required %h", bits[FL-1:0], exp); end
        n_cmp++;
        if (under_cnt - u0 != 1) begin n_err++; $display("FAIL simul_underrun: got %0d required 1", under_cnt - u0); end
        n_cmp++;
        if (din_rdy !== 1'b0) begin n_err++; $display("FAIL simul_buf_full: din_rdy=%b required 0", din_rdy); end
        exp_q.push_back({2'b00, 16'h1234});
        run_frame(18, 1'b0, 16'h0, -1, bits, sd, rdy);
        exp = exp_q.pop_front();
        n_cmp++;
        if (bits[FL-1:0] !== exp) begin n_err++; $display("FAIL simul_next_bits: got %h required %h", bits[FL-1:0], exp); end
        n_cmp++;
        if (under_cnt - u0 != 1) begin n_err++; $display("FAIL simul_next_underrun: got %0d required 1", under_cnt - u0); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] bits;
        logic [FL-1:0] exp;
        logic sd, rdy;
        int d0 = done_cnt, a0 = abort_cnt, u0 = under_cnt;
        load_word(16'hFFFF);
        run_frame(18, 1'b0, 16'h0, 7, bits, sd, rdy);
        n_cmp++;
        if (bits[17:11] !== 7'b0011111) begin n_err++; $display("FAIL mid_pre_bits: got %b required 0011111", bits[17:11]); end
        n_cmp++;
        if (sd !== 1'b0) begin n_err++; $display("FAIL mid_sdata: got %b required 0", sd); end
        n_cmp++;
        if (rdy !== 1'b0) begin n_err++; $display("FAIL mid_rdy: got %b required 0", rdy); end
        n_cmp++;
        if (done_cnt != d0 || abort_cnt != a0 || under_cnt != u0) begin
            n_err++;
            $display("FAIL mid_pulses: done %0d abort %0d under %0d required 0 0 0",
                     done_cnt - d0, abort_cnt - a0, under_cnt - u0);
        end
        exp_q.push_back(18'h0);
        run_frame(18, 1'b0, 16'h0, -1, bits, sd, rdy);
        exp = exp_q.pop_front();
        n_cmp++;
        if (bits[FL-1:0] !== exp) begin n_err++; $display("FAIL mid_after_bits: got %h required %h", bits[FL-1:0], exp); end
        n_cmp++;
        if (under_cnt - u0 != 1 || done_cnt - d0 != 1) begin
            n_err++;
            $display("FAIL mid_after_pulses: under %0d done %0d required 1 1", under_cnt - u0, done_cnt - d0);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_underrun();
        test_abort();
        test_long_frame();
        test_back_to_back();
        test_reset_mid();
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL queue_empty: got %0d entries required 0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
